// File: rtl/npu_pkg.sv
// Shared widths, conv FSM state encoding and frame bookkeeping for the NPU datapath.
package npu_pkg;

  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 22;
  localparam int PROD_W = PIX_W + WGT_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    RUN    = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } conv_state_t;

  function automatic int unsigned num_results(input int unsigned w, input int unsigned h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: dout is the pixel pushed DEPTH accepted pixels ago.
module conv_line_buffer
  import npu_pkg::*;
#(
  parameter int DEPTH = 28
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic signed [PIX_W-1:0] din,
  output logic signed [PIX_W-1:0] dout
);

  logic signed [PIX_W-1:0] mem [DEPTH];

  assign dout = mem[DEPTH-1];

  // Contents are not reset; the window valid logic in the parent masks stale rows.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

endmodule

// File: rtl/conv2d_3x3.sv
// Streaming 3x3 valid convolution: line buffers + window, two-stage multiply/accumulate.
module conv2d_3x3
  import npu_pkg::*;
#(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_signal,
  input  logic                     weight_valid,
  input  logic signed [WGT_W-1:0]  weight_in,
  input  logic signed [BIAS_W-1:0] bias_in,
  input  logic                     pixel_valid,
  input  logic signed [PIX_W-1:0]  pixel_in,
  output logic signed [ACC_W-1:0]  result_out,
  output logic                     result_valid,
  output logic                     done_signal,
  output logic                     busy
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  conv_state_t state, next_state;

  logic [3:0]              wcnt;
  logic [XW-1:0]           x;
  logic [YW-1:0]           y;
  logic signed [WGT_W-1:0] w [9];
  logic signed [BIAS_W-1:0] bias;
  logic signed [PIX_W-1:0] win [9];
  logic signed [PIX_W-1:0] row1, row2;
  logic signed [PROD_W-1:0] prod [9];
  logic signed [ACC_W-1:0] sum_c;
  logic                    win_valid, prod_valid;
  logic                    start_acc, w_acc, p_acc, last_w, last_p, x_last;

  assign start_acc = (state == IDLE) && start_signal;
  assign w_acc     = (state == LOAD_W) && weight_valid;
  assign p_acc     = (state == RUN) && pixel_valid;
  assign last_w    = (wcnt == 4'd8);
  assign x_last    = (x == XW'(IMG_WIDTH - 1));
  assign last_p    = x_last && (y == YW'(IMG_HEIGHT - 1));

  always_comb begin
    next_state  = state;
    done_signal = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:   if (start_signal) next_state = LOAD_W;
      LOAD_W: if (weight_valid && last_w) next_state = RUN;
      RUN:    if (pixel_valid && last_p) next_state = FLUSH;
      // The final result is on the output when nothing remains behind it.
      FLUSH:  if (result_valid && !prod_valid && !win_valid) next_state = DONE;
      DONE: begin
        done_signal = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      x     <= '0;
      y     <= '0;
      bias  <= '0;
      for (int unsigned i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      state <= next_state;
      if (start_acc) begin
        bias <= bias_in;
        wcnt <= '0;
        x    <= '0;
        y    <= '0;
      end
      if (w_acc) begin
        w[wcnt] <= weight_in;
        wcnt    <= wcnt + 4'd1;
      end
      if (p_acc) begin
        if (x_last) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk  (clk),
    .en   (p_acc),
    .din  (pixel_in),
    .dout (row1)
  );

  conv_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk  (clk),
    .en   (p_acc),
    .din  (row1),
    .dout (row2)
  );

  // Window index is ky*3+kx; the newest column enters at kx=2.
  always_ff @(posedge clk) begin
    if (p_acc) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= row2;
      win[5] <= row1;
      win[8] <= pixel_in;
    end
    for (int unsigned i = 0; i < 9; i++) begin
      prod[i] <= PROD_W'(w[i]) * PROD_W'(win[i]);
    end
  end

  always_comb begin
    sum_c = ACC_W'(bias);
    for (int unsigned i = 0; i < 9; i++) begin
      sum_c = sum_c + ACC_W'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid    <= 1'b0;
      prod_valid   <= 1'b0;
      result_valid <= 1'b0;
      result_out   <= '0;
    end else begin
      win_valid    <= p_acc && (x >= XW'(2)) && (y >= YW'(2));
      prod_valid   <= win_valid;
      result_valid <= prod_valid;
      if (prod_valid) result_out <= sum_c;
    end
  end

endmodule

// File: doc/conv2d_3x3.md
CONV2D_3X3 -- requirements
Module: conv2d_3x3

Interface
REQ-001 The block SHALL take parameters: IMG_WIDTH, default 28, input image width in pixels (minimum 3).
REQ-002 The block SHALL take parameters: IMG_HEIGHT, default 28, input image height in pixels (minimum 3).
REQ-003 The block SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_signal  in  1  one-cycle pulse that begins a frame.
- weight_valid  in  1  weight_in qualifier.
- weight_in  in  8 signed  kernel tap, raster order w0..w8.
- bias_in  in  16 signed  bias, sampled on the start_signal cycle.
- pixel_valid  in  1  pixel_in qualifier.
- pixel_in  in  8 signed  input pixel, raster order.
- result_out  out  22 signed  convolution result.
- result_valid  out  1  result_out qualifier, one cycle per result.
- done_signal  out  1  one-cycle pulse when the frame is complete.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD_W, RUN, FLUSH, DONE.
REQ-005 Transitions:
- IDLE -> LOAD_W on start_signal.
- LOAD_W -> RUN after the 9th accepted weight.
- RUN -> FLUSH after IMG_WIDTH*IMG_HEIGHT accepted pixels.
- FLUSH -> DONE when the pipeline is empty.
- DONE -> IDLE unconditionally.
REQ-006 start_signal SHALL be ignored outside IDLE.
REQ-007 Weights SHALL be ignored outside LOAD_W.
REQ-008 Pixels SHALL be ignored outside RUN.
REQ-009 In LOAD_W, each weight_valid cycle SHALL store weight_in into tap k, where k counts 0..8.
REQ-010 In RUN, pixel_valid gaps of any length SHALL be tolerated; the x/y counters SHALL advance only on accepted pixels.
REQ-011 The x counter SHALL wrap to 0 at IMG_WIDTH-1 and increment the y counter.
REQ-012 The block SHALL keep two line buffers of IMG_WIDTH x 8 bits plus a 3x3 window register.
REQ-013 The window SHALL be valid when the accepted pixel has x>=2 and y>=2 (valid convolution, no padding).
REQ-014 The block SHALL produce (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame, in raster order.
REQ-015 The result SHALL be computed as: result = bias + sum over ky,kx of w[ky*3+kx] * pix(x-2+kx, y-2+ky).
REQ-016 Products SHALL be 16-bit signed, and the sum SHALL be sign-extended to 22 bits.
REQ-017 No saturation SHALL be applied, because the worst case (|sum| <= 147456 + 32768) fits in 22 bits.
REQ-018 The pipeline SHALL have two stages: stage 1 registers the 9 products, stage 2 registers the adder tree plus bias.
REQ-019 result_valid SHALL rise exactly 2 cycles after the clock edge that accepts the window-completing pixel.
REQ-020 The pipeline SHALL advance every cycle; valid bits SHALL be carried alongside the data.
REQ-021 done_signal SHALL pulse for exactly one cycle, in DONE, exactly one cycle after the final result_valid.
REQ-022 result_out SHALL hold its last value when result_valid is low.
REQ-023 A new start_signal SHALL be accepted on the cycle after DONE, i.e. in IDLE.
REQ-024 Weights and bias SHALL persist until the next LOAD_W.

Reset
REQ-025 rst_n low SHALL asynchronously force the FSM to IDLE.
REQ-026 rst_n low SHALL clear all counters, pipeline valid bits, weights and bias.
REQ-027 rst_n low SHALL drive result_out=0, result_valid=0, done_signal=0 and busy=0.
REQ-028 Reset asserted mid-frame SHALL discard all in-flight results and SHALL NOT produce done_signal.
REQ-029 Line buffer contents need no reset, because the window valid logic masks stale data.

Structure
REQ-030 Shared package npu_pkg SHALL hold:
- PIX_W=8, WGT_W=8, BIAS_W=16, ACC_W=22.
- The conv FSM state enum.
- The results-count helper function.
REQ-031 One sub-module, conv_line_buffer, SHALL implement a single IMG_WIDTH-deep, 8-bit shift or circular buffer; conv2d_3x3 SHALL instantiate two of them.
REQ-032 The ACC_W output width SHALL match the 22-bit input of the downstream Max_Pooling stage, so the two connect directly.

Verification
REQ-033 The bench SHALL cover, with IMG_WIDTH=IMG_HEIGHT=4:
- Basic frame: all weights 1, bias 0, pixels 1..16 -> results 54, 63, 90, 99 in order; then done_signal one cycle after the last result.
- Identity kernel: w4=1, all other weights 0, bias -5, pixels 1..16 -> results 1, 2, 5, 6.
- Extremes: all weights -128, all pixels -128, bias 32767 -> every result 180223, with no wrap.
- Throttling: random pixel_valid gaps -> the same 54, 63, 90, 99; each result_valid exactly 2 cycles after its completing pixel.
- Reset mid-frame: rst_n low after pixel 10 -> outputs 0 immediately and no done_signal; a following full frame yields 54, 63, 90, 99.
- Protocol: start_signal during RUN and pixel_valid during IDLE -> ignored; the result count stays 4.
